// File: rtl/regfile_bank_if.sv
// Bus bundle for the register bank: one write port, bulk clear, two read
// ports, plus the status outputs (write error pulse and valid-entry count).
interface regfile_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              clr;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic              rd_valid_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_valid_b;
    logic              wr_err;
    logic [ADDR_W:0]   count;

    // The user of the bank drives requests and observes results.
    modport master (
        output wr_en, wr_addr, wr_data, clr,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
        input  wr_err, count
    );

    // The bank itself receives requests and produces results.
    modport slave (
        input  wr_en, wr_addr, wr_data, clr,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
        output wr_err, count
    );
endinterface

// File: rtl/regfile_bank.sv
// WIDTH x DEPTH register bank with per-entry valid bits, one write port,
// two independent registered read ports with write-to-read bypass, a
// synchronous bulk clear and out-of-range address detection.
module regfile_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_bank_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic             rd_valid_a_q, rd_valid_a_d;
    logic             rd_valid_b_q, rd_valid_b_d;
    logic             wr_err_q, wr_err_d;
    logic [ADDR_W:0]  count_q, count_d;

    logic wr_in_range, rd_in_range_a, rd_in_range_b, wr_hit;

    assign wr_in_range   = {1'b0, bus.wr_addr}   < DEPTH_L;
    assign rd_in_range_a = {1'b0, bus.rd_addr_a} < DEPTH_L;
    assign rd_in_range_b = {1'b0, bus.rd_addr_b} < DEPTH_L;
    // A write only lands when it is in range and not overridden by clear.
    assign wr_hit        = bus.wr_en && !bus.clr && wr_in_range;

    // Next storage contents: clear wipes everything, otherwise apply the write.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            valid_d = '0;
        end else if (wr_hit) begin
            mem_d[bus.wr_addr]   = bus.wr_data;
            valid_d[bus.wr_addr] = 1'b1;
        end
    end

    // Count grows only when a write fills a previously empty entry.
    always_comb begin
        count_d = count_q;
        if (bus.clr) begin
            count_d = '0;
        end else if (wr_hit && !valid_q[bus.wr_addr]) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end
    end

    // Error pulse flags an out-of-range write that was not masked by clear.
    always_comb begin
        wr_err_d = bus.wr_en && !bus.clr && !wr_in_range;
    end

    // Port A read: clear forces zero, bypass returns fresh write data.
    always_comb begin
        rd_data_a_d  = rd_data_a_q;
        rd_valid_a_d = rd_valid_a_q;
        if (bus.rd_en_a) begin
            if (bus.clr || !rd_in_range_a) begin
                rd_data_a_d  = '0;
                rd_valid_a_d = 1'b0;
            end else if (wr_hit && (bus.wr_addr == bus.rd_addr_a)) begin
                rd_data_a_d  = bus.wr_data;
                rd_valid_a_d = 1'b1;
            end else begin
                rd_data_a_d  = mem_q[bus.rd_addr_a];
                rd_valid_a_d = valid_q[bus.rd_addr_a];
            end
        end
    end

    // Port B read: identical rules, fully independent of port A.
    always_comb begin
        rd_data_b_d  = rd_data_b_q;
        rd_valid_b_d = rd_valid_b_q;
        if (bus.rd_en_b) begin
            if (bus.clr || !rd_in_range_b) begin
                rd_data_b_d  = '0;
                rd_valid_b_d = 1'b0;
            end else if (wr_hit && (bus.wr_addr == bus.rd_addr_b)) begin
                rd_data_b_d  = bus.wr_data;
                rd_valid_b_d = 1'b1;
            end else begin
                rd_data_b_d  = mem_q[bus.rd_addr_b];
                rd_valid_b_d = valid_q[bus.rd_addr_b];
            end
        end
    end

    // All state registers, asynchronously zeroed by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q      <= '0;
            rd_data_a_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_data_b_q  <= '0;
            rd_valid_b_q <= 1'b0;
            wr_err_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            mem_q        <= mem_d;
            valid_q      <= valid_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_b_q <= rd_valid_b_d;
            wr_err_q     <= wr_err_d;
            count_q      <= count_d;
        end
    end

    assign bus.rd_data_a  = rd_data_a_q;
    assign bus.rd_valid_a = rd_valid_a_q;
    assign bus.rd_data_b  = rd_data_b_q;
    assign bus.rd_valid_b = rd_valid_b_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.count      = count_q;

endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: two instances (DEPTH 8 and DEPTH 6) see the same
// stimulus; a behavioural model predicts each cycle's outputs, which are
// queued when stimulus is driven and compared one clock later.
module tb_regfile_bank;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    regfile_bank_if #(.WIDTH(8), .ADDR_W(3)) bus8 ();
    regfile_bank_if #(.WIDTH(8), .ADDR_W(3)) bus6 ();

    regfile_bank #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    regfile_bank #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6.slave)
    );

    typedef struct {
        logic [7:0] da;
        logic       va;
        logic [7:0] db;
        logic       vb;
        logic       err;
        logic [3:0] cnt;
    } expT;

    expT sbQ[$];

    int compareCount  = 0;
    int mismatchCount = 0;

    // Model state, index 0 = DEPTH 8 instance, index 1 = DEPTH 6 instance.
    int         mDepth [2] = '{8, 6};
    logic [7:0] mMem   [2][8];
    logic       mValid [2][8];
    logic [3:0] mCount [2];
    logic [7:0] pDA    [2];
    logic       pVA    [2];
    logic [7:0] pDB    [2];
    logic       pVB    [2];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkInst(input string tag, input logic [7:0] da, input logic va,
                             input logic [7:0] db, input logic vb, input logic err,
                             input logic [3:0] cnt, input expT e);
        checkOutput({tag, " rdDataA"},  32'(da),  32'(e.da));
        checkOutput({tag, " rdValidA"}, 32'(va),  32'(e.va));
        checkOutput({tag, " rdDataB"},  32'(db),  32'(e.db));
        checkOutput({tag, " rdValidB"}, 32'(vb),  32'(e.vb));
        checkOutput({tag, " wrErr"},    32'(err), 32'(e.err));
        checkOutput({tag, " count"},    32'(cnt), 32'(e.cnt));
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                mMem[k][i]   = 8'h00;
                mValid[k][i] = 1'b0;
            end
            mCount[k] = 4'd0;
            pDA[k] = 8'h00; pVA[k] = 1'b0;
            pDB[k] = 8'h00; pVB[k] = 1'b0;
        end
    endtask

    task automatic driveInputs(input logic wrEn, input logic [2:0] wrAddr,
                               input logic [7:0] wrData, input logic clr,
                               input logic rdEnA, input logic [2:0] addrA,
                               input logic rdEnB, input logic [2:0] addrB);
        bus8.wr_en = wrEn; bus8.wr_addr = wrAddr; bus8.wr_data = wrData; bus8.clr = clr;
        bus8.rd_en_a = rdEnA; bus8.rd_addr_a = addrA;
        bus8.rd_en_b = rdEnB; bus8.rd_addr_b = addrB;
        bus6.wr_en = wrEn; bus6.wr_addr = wrAddr; bus6.wr_data = wrData; bus6.clr = clr;
        bus6.rd_en_a = rdEnA; bus6.rd_addr_a = addrA;
        bus6.rd_en_b = rdEnB; bus6.rd_addr_b = addrB;
    endtask

    // One clocked transaction: drive, predict and queue, then compare after the edge.
    task automatic applyStimulus(input string tag, input logic wrEn, input logic [2:0] wrAddr,
                                 input logic [7:0] wrData, input logic clr,
                                 input logic rdEnA, input logic [2:0] addrA,
                                 input logic rdEnB, input logic [2:0] addrB);
        expT e;
        @(negedge clk);
        driveInputs(wrEn, wrAddr, wrData, clr, rdEnA, addrA, rdEnB, addrB);
        for (int k = 0; k < 2; k++) begin
            bit inR;
            bit hit;
            inR = int'(wrAddr) < mDepth[k];
            hit = wrEn && !clr && inR;
            if (rdEnA) begin
                if (clr || int'(addrA) >= mDepth[k]) begin
                    pDA[k] = 8'h00; pVA[k] = 1'b0;
                end else if (hit && addrA == wrAddr) begin
                    pDA[k] = wrData; pVA[k] = 1'b1;
                end else begin
                    pDA[k] = mMem[k][addrA]; pVA[k] = mValid[k][addrA];
                end
            end
            if (rdEnB) begin
                if (clr || int'(addrB) >= mDepth[k]) begin
                    pDB[k] = 8'h00; pVB[k] = 1'b0;
                end else if (hit && addrB == wrAddr) begin
                    pDB[k] = wrData; pVB[k] = 1'b1;
                end else begin
                    pDB[k] = mMem[k][addrB]; pVB[k] = mValid[k][addrB];
                end
            end
            if (clr) begin
                for (int i = 0; i < 8; i++) begin
                    mMem[k][i] = 8'h00; mValid[k][i] = 1'b0;
                end
                mCount[k] = 4'd0;
            end else if (hit) begin
                if (!mValid[k][wrAddr]) mCount[k] = mCount[k] + 4'd1;
                mMem[k][wrAddr]   = wrData;
                mValid[k][wrAddr] = 1'b1;
            end
            e.da = pDA[k]; e.va = pVA[k]; e.db = pDB[k]; e.vb = pVB[k];
            e.err = wrEn && !clr && !inR;
            e.cnt = mCount[k];
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        e = sbQ.pop_front();
        checkInst({tag, "/d8"}, bus8.rd_data_a, bus8.rd_valid_a, bus8.rd_data_b,
                  bus8.rd_valid_b, bus8.wr_err, bus8.count, e);
        e = sbQ.pop_front();
        checkInst({tag, "/d6"}, bus6.rd_data_a, bus6.rd_valid_a, bus6.rd_data_b,
                  bus6.rd_valid_b, bus6.wr_err, bus6.count, e);
    endtask

    // Outputs of both instances must all read zero right now.
    task automatic checkAllZero(input string tag);
        expT z;
        z = '{da: 8'h00, va: 1'b0, db: 8'h00, vb: 1'b0, err: 1'b0, cnt: 4'd0};
        checkInst({tag, "/d8"}, bus8.rd_data_a, bus8.rd_valid_a, bus8.rd_data_b,
                  bus8.rd_valid_b, bus8.wr_err, bus8.count, z);
        checkInst({tag, "/d6"}, bus6.rd_data_a, bus6.rd_valid_a, bus6.rd_data_b,
                  bus6.rd_valid_b, bus6.wr_err, bus6.count, z);
    endtask

    initial begin
        rst_n = 1'b1;
        driveInputs(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        modelReset();

        // Reset pulse and read-before-write
        #2 rst_n = 1'b0;
        #1 checkAllZero("resetAsync");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("readEmpty", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);

        // Basic write and dual-port read
        applyStimulus("write2",   1'b1, 3'd2, 8'hA5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        applyStimulus("write7",   1'b1, 3'd7, 8'h3C, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        applyStimulus("readA2B7", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1, 3'd7);

        // Bypass with overwrite, then hold when read is disabled
        applyStimulus("bypass2", 1'b1, 3'd2, 8'h5A, 1'b0, 1'b1, 3'd2, 1'b1, 3'd7);
        applyStimulus("holdA",   1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2);

        // Out-of-range write and read (range edge for DEPTH 6)
        applyStimulus("write6",  1'b1, 3'd6, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        applyStimulus("read6",   1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b1, 3'd5);
        applyStimulus("errDrop", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

        // Fill, then clear with a colliding write and read
        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("fill%0d", i), 1'b1, 3'(i), 8'(8'h10 + i), 1'b0,
                          1'b0, 3'd0, 1'b0, 3'd0);
        end
        applyStimulus("clrPrio",  1'b1, 3'd1, 8'h11, 1'b1, 1'b1, 3'd1, 1'b1, 3'd0);
        applyStimulus("afterClr", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1, 3'd7);

        // Async reset in the middle of a write stream
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("stream%0d", i), 1'b1, 3'(i), 8'(8'h40 + i), 1'b0,
                          1'b1, 3'(i), 1'b0, 3'd0);
        end
        @(negedge clk);
        driveInputs(1'b1, 3'd4, 8'h77, 1'b0, 1'b1, 3'd0, 1'b1, 3'd1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("midReset");
        modelReset();
        driveInputs(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("postRst01", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 3'd1);
        applyStimulus("postRst23", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1, 3'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
